// File: rtl/register_file_2w.sv
// ----------------------------------------------------------------------------
// register_file_2w
//
// Purpose:
//   General-purpose register file with two combinational read ports and two
//   synchronous write ports. Optional hardwired-zero register 0 and optional
//   same-cycle write-to-read forwarding.
//
// Parameters:
//   WIDTH    - data width of every register and data port
//   ADDR_W   - address width; the file holds DEPTH = 2**ADDR_W registers
//   ZERO_REG - 1: register 0 always reads 0 and ignores writes
//   BYPASS   - 1: a write presented this cycle is visible on a matching
//              read port before the clock edge
//
// Ports:
//   clk        in   sole clock, all state changes on the rising edge
//   reset      in   synchronous active-high reset, clears every register
//   RR1, RR2   in   read addresses
//   WR         in   write address, write port 1
//   RegWrite   in   write enable, write port 1
//   WD         in   write data, write port 1
//   WR2        in   write address, write port 2
//   RegWrite2  in   write enable, write port 2
//   WD2        in   write data, write port 2
//   RD1, RD2   out  combinational read data
//
// Write port 2 has priority over write port 1: on an address collision the
// register takes WD2, and forwarding likewise prefers WD2.
// ----------------------------------------------------------------------------
module register_file_2w #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RR1,
    input  logic [ADDR_W-1:0] RR2,
    input  logic [ADDR_W-1:0] WR,
    input  logic              RegWrite,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] WR2,
    input  logic              RegWrite2,
    input  logic [WIDTH-1:0]  WD2,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];

    // Effective write enables: a write aimed at a hardwired-zero register 0
    // is dropped here, so neither storage nor forwarding ever sees it.
    logic we1_eff;
    logic we2_eff;

    assign we1_eff = RegWrite  && !((ZERO_REG != 0) && (WR  == '0));
    assign we2_eff = RegWrite2 && !((ZERO_REG != 0) && (WR2 == '0));

    // Storage. Reset wins over both write ports; port 2 wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (we2_eff && (WR2 == ADDR_W'(i))) begin
                    regs[i] <= WD2;
                end else if (we1_eff && (WR == ADDR_W'(i))) begin
                    regs[i] <= WD;
                end
            end
        end
    end

    // Read mux for one port. Forwarding is suppressed during reset so the
    // port shows stored contents; port 2 is checked last so it takes
    // precedence. A zero-register read overrides everything.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [WIDTH-1:0]  stored,
        input logic              rst,
        input logic              w1,
        input logic [ADDR_W-1:0] a1,
        input logic [WIDTH-1:0]  d1,
        input logic              w2,
        input logic [ADDR_W-1:0] a2,
        input logic [WIDTH-1:0]  d2
    );
        logic [WIDTH-1:0] v;
        v = stored;
        if ((BYPASS != 0) && !rst) begin
            if (w1 && (a1 == addr)) begin
                v = d1;
            end
            if (w2 && (a2 == addr)) begin
                v = d2;
            end
        end
        if ((ZERO_REG != 0) && (addr == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    assign RD1 = read_port(RR1, regs[RR1], reset, we1_eff, WR, WD, we2_eff, WR2, WD2);
    assign RD2 = read_port(RR2, regs[RR2], reset, we1_eff, WR, WD, we2_eff, WR2, WD2);

endmodule

// File: tb/tb_register_file_2w.sv
module tb_register_file_2w;

  logic        clk;
  logic        reset;

  // Shared stimulus for the default build and the no-bypass build
  logic [4:0]  rr1, rr2, wr, wr2;
  logic        we, we2;
  logic [31:0] wd, wd2;
  logic [31:0] rd1, rd2;        // default: ZERO_REG=1, BYPASS=1
  logic [31:0] rd1_nb, rd2_nb;  // ZERO_REG=0, BYPASS=0

  // Small build: WIDTH=8, ADDR_W=3
  logic [2:0]  s_rr1, s_rr2, s_wr, s_wr2;
  logic        s_we, s_we2;
  logic [7:0]  s_wd, s_wd2;
  logic [7:0]  s_rd1, s_rd2;

  int n_pass;
  int n_total;

  register_file_2w dut (
    .clk(clk), .reset(reset),
    .RR1(rr1), .RR2(rr2),
    .WR(wr), .RegWrite(we), .WD(wd),
    .WR2(wr2), .RegWrite2(we2), .WD2(wd2),
    .RD1(rd1), .RD2(rd2)
  );

  register_file_2w #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset),
    .RR1(rr1), .RR2(rr2),
    .WR(wr), .RegWrite(we), .WD(wd),
    .WR2(wr2), .RegWrite2(we2), .WD2(wd2),
    .RD1(rd1_nb), .RD2(rd2_nb)
  );

  register_file_2w #(.WIDTH(8), .ADDR_W(3)) dut_s (
    .clk(clk), .reset(reset),
    .RR1(s_rr1), .RR2(s_rr2),
    .WR(s_wr), .RegWrite(s_we), .WD(s_wd),
    .WR2(s_wr2), .RegWrite2(s_we2), .WD2(s_wd2),
    .RD1(s_rd1), .RD2(s_rd2)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver tasks ----------------
  // Advance past the next rising edge; inputs change and outputs are
  // sampled 1 time unit after it, well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_writes();
    we = 1'b0; we2 = 1'b0; s_we = 1'b0; s_we2 = 1'b0;
  endtask

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    wr = a; wd = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle_writes();
    rr1 = '0; rr2 = '0; wr = '0; wr2 = '0; wd = '0; wd2 = '0;
    s_rr1 = '0; s_rr2 = '0; s_wr = '0; s_wr2 = '0; s_wd = '0; s_wd2 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      rr1 = 5'(i); rr2 = 5'(31 - i);
      #1;
      n_total++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL reset_main addr=%0d rd1=%h rd2=%h expected 0", i, rd1, rd2);
      else n_pass++;
      n_total++;
      if (rd1_nb !== 32'd0 || rd2_nb !== 32'd0) $display("FAIL reset_nb addr=%0d rd1=%h rd2=%h expected 0", i, rd1_nb, rd2_nb);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    write1(5'd2, 32'd23);
    write1(5'd3, 32'd28);
    rr1 = 5'd2; rr2 = 5'd3;
    #1;
    n_total++;
    if (rd1 !== 32'd23) $display("FAIL basic_rd1 got %0d expected 23", rd1); else n_pass++;
    n_total++;
    if (rd2 !== 32'd28) $display("FAIL basic_rd2 got %0d expected 28", rd2); else n_pass++;
    n_total++;
    if (rd1_nb !== 32'd23 || rd2_nb !== 32'd28) $display("FAIL basic_nb got %0d/%0d expected 23/28", rd1_nb, rd2_nb); else n_pass++;
  endtask

  task automatic test_bypass();
    // Port 1 forwarding onto RD1
    rr1 = 5'd5; wr = 5'd5; wd = 32'd55; we = 1'b1;
    #1;
    n_total++;
    if (rd1 !== 32'd55) $display("FAIL bypass_p1 got %0d expected 55", rd1); else n_pass++;
    n_total++;
    if (rd1_nb !== 32'd0) $display("FAIL nobypass_old got %0d expected 0", rd1_nb); else n_pass++;
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rd1 !== 32'd55 || rd1_nb !== 32'd55) $display("FAIL bypass_after got %0d/%0d expected 55/55", rd1, rd1_nb); else n_pass++;
    // Port 2 forwarding onto RD2
    rr2 = 5'd6; wr2 = 5'd6; wd2 = 32'd66; we2 = 1'b1;
    #1;
    n_total++;
    if (rd2 !== 32'd66) $display("FAIL bypass_p2 got %0d expected 66", rd2); else n_pass++;
    tick();
    we2 = 1'b0;
    // Both ports target 10 while RR1=RR2=10: WD2 wins
    rr1 = 5'd10; rr2 = 5'd10;
    wr = 5'd10; wd = 32'd1; we = 1'b1;
    wr2 = 5'd10; wd2 = 32'd2; we2 = 1'b1;
    #1;
    n_total++;
    if (rd1 !== 32'd2 || rd2 !== 32'd2) $display("FAIL bypass_prec got %0d/%0d expected 2/2", rd1, rd2); else n_pass++;
    tick();
    idle_writes();
    #1;
    n_total++;
    if (rd1 !== 32'd2 || rd2_nb !== 32'd2) $display("FAIL prec_stored got %0d/%0d expected 2/2", rd1, rd2_nb); else n_pass++;
  endtask

  task automatic test_collision();
    wr = 5'd7; wd = 32'd11; we = 1'b1;
    wr2 = 5'd7; wd2 = 32'd99; we2 = 1'b1;
    tick();
    idle_writes();
    rr1 = 5'd7;
    #1;
    n_total++;
    if (rd1 !== 32'd99 || rd1_nb !== 32'd99) $display("FAIL collision got %0d/%0d expected 99", rd1, rd1_nb); else n_pass++;
    wr = 5'd8; wd = 32'd1; we = 1'b1;
    wr2 = 5'd9; wd2 = 32'd2; we2 = 1'b1;
    tick();
    idle_writes();
    rr1 = 5'd8; rr2 = 5'd9;
    #1;
    n_total++;
    if (rd1 !== 32'd1 || rd2 !== 32'd2) $display("FAIL distinct got %0d/%0d expected 1/2", rd1, rd2); else n_pass++;
    n_total++;
    if (rd1_nb !== 32'd1 || rd2_nb !== 32'd2) $display("FAIL distinct_nb got %0d/%0d expected 1/2", rd1_nb, rd2_nb); else n_pass++;
  endtask

  task automatic test_zero();
    rr1 = 5'd0; rr2 = 5'd0;
    wr = 5'd0; wd = 32'hFFFF_FFFF; we = 1'b1;
    #1;
    n_total++;
    if (rd1 !== 32'd0) $display("FAIL zero_bypass_p1 got %h expected 0", rd1); else n_pass++;
    tick();
    we = 1'b0;
    #1;
    n_total++;
    if (rd1 !== 32'd0) $display("FAIL zero_store_p1 got %h expected 0", rd1); else n_pass++;
    n_total++;
    if (rd1_nb !== 32'hFFFF_FFFF) $display("FAIL nozero_store got %h expected ffffffff", rd1_nb); else n_pass++;
    wr2 = 5'd0; wd2 = 32'hFFFF_FFFF; we2 = 1'b1;
    #1;
    n_total++;
    if (rd2 !== 32'd0) $display("FAIL zero_bypass_p2 got %h expected 0", rd2); else n_pass++;
    wd2 = 32'h1234_5678;
    tick();
    we2 = 1'b0;
    #1;
    n_total++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL zero_store_p2 got %h/%h expected 0", rd1, rd2); else n_pass++;
    n_total++;
    if (rd2_nb !== 32'h1234_5678) $display("FAIL nozero_p2 got %h expected 12345678", rd2_nb); else n_pass++;
  endtask

  task automatic test_reset_mid();
    // regs 2 and 3 still hold 23 and 28
    reset = 1'b1;
    wr = 5'd4; wd = 32'd77; we = 1'b1;
    wr2 = 5'd3; wd2 = 32'd55; we2 = 1'b1;
    rr1 = 5'd4; rr2 = 5'd3;
    #1;
    n_total++;
    if (rd1 !== 32'd0) $display("FAIL rst_nofwd_p1 got %0d expected 0", rd1); else n_pass++;
    n_total++;
    if (rd2 !== 32'd28) $display("FAIL rst_nofwd_p2 got %0d expected 28", rd2); else n_pass++;
    tick();
    reset = 1'b0;
    idle_writes();
    rr1 = 5'd2; rr2 = 5'd3;
    #1;
    n_total++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) $display("FAIL rst_mid_23 got %0d/%0d expected 0/0", rd1, rd2); else n_pass++;
    rr1 = 5'd4;
    #1;
    n_total++;
    if (rd1 !== 32'd0 || rd1_nb !== 32'd0) $display("FAIL rst_mid_4 got %0d/%0d expected 0/0", rd1, rd1_nb); else n_pass++;
  endtask

  task automatic test_sweep();
    s_wr = 3'd7; s_wd = 8'hA5; s_we = 1'b1;
    tick();
    s_we = 1'b0;
    s_rr1 = 3'd7;
    #1;
    n_total++;
    if (s_rd1 !== 8'hA5) $display("FAIL sweep_a5 got %h expected a5", s_rd1); else n_pass++;
    // Fill all addresses, two per edge: even via port 1, odd via port 2
    for (int i = 0; i < 8; i += 2) begin
      s_wr = 3'(i); s_wd = 8'(8'h10 + i); s_we = 1'b1;
      s_wr2 = 3'(i + 1); s_wd2 = 8'(8'h10 + i + 1); s_we2 = 1'b1;
      tick();
    end
    idle_writes();
    for (int i = 0; i < 8; i++) begin
      s_rr1 = 3'(i); s_rr2 = 3'(7 - i);
      #1;
      n_total++;
      if (s_rd1 !== ((i == 0) ? 8'h00 : 8'(8'h10 + i)))
        $display("FAIL sweep_rd1 addr=%0d got %h expected %h", i, s_rd1, (i == 0) ? 8'h00 : 8'(8'h10 + i));
      else n_pass++;
      n_total++;
      if (s_rd2 !== ((i == 7) ? 8'h00 : 8'(8'h17 - i)))
        $display("FAIL sweep_rd2 addr=%0d got %h expected %h", 7 - i, s_rd2, (i == 7) ? 8'h00 : 8'(8'h17 - i));
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_basic();
    test_bypass();
    test_collision();
    test_zero();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
